// File: rtl/keypad_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner_pkg
// Brief    : Shared FSM states, key codes and key-mapping helpers for the
//            4x3 matrix keypad scanner.
// Revision : 1.0 - initial release
// ============================================================================
package keypad_scanner_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] KEY_STAR  = 4'd10;
    localparam logic [3:0] KEY_HASH  = 4'd11;
    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    // Rows 0..2 carry digits 1..9 in reading order; row 3 is "* 0 #".
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
        end
        return code;
    endfunction

    function automatic logic [9:0] digit_onehot(input logic [3:0] code);
        return (code < 4'd10) ? (10'd1 << code) : 10'd0;
    endfunction

    function automatic logic single_low(input logic [3:0] rows);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, ~rows[i]};
        end
        return (n == 3'd1);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [2:0] col_drive(input logic [1:0] col);
        return ~(3'b001 << col);
    endfunction

    function automatic logic [1:0] next_col(input logic [1:0] col);
        return (col == 2'd2) ? 2'd0 : col + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop synchronizer for asynchronous level inputs.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : Scans a 4x3 matrix keypad, debounces presses/releases and
//            drives the one-hot digit bus plus key code and valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 20,
    parameter int COL_DWELL    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [2:0] key_col,
    output logic [9:0] keypad,
    output logic [3:0] key_code,
    output logic       key_valid
);

    localparam int               PHASE_W    = $clog2(COL_DWELL);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(COL_DWELL - 1);
    localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);
    localparam logic [7:0]       DEB_LAST   = 8'(DEBOUNCE_CYC);

    logic [3:0]         row_s;
    state_t             state,    state_n;
    logic [1:0]         col_idx,  col_idx_n;
    logic [PHASE_W-1:0] phase,    phase_n;
    logic [7:0]         cnt,      cnt_n;
    logic [1:0]         cand_row, cand_row_n;
    logic [1:0]         cand_col, cand_col_n;
    logic [9:0]         keypad_n;
    logic [3:0]         key_code_n;
    logic               key_valid_n;
    logic [3:0]         cand_pattern;
    logic [3:0]         cand_code;
    logic [7:0]         cnt_inc;

    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL (4'b1111)
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_row),
        .q   (row_s)
    );

    assign cand_pattern = ~(4'b0001 << cand_row);
    assign cand_code    = key_map(cand_row, cand_col);
    assign cnt_inc      = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SCAN;
            col_idx   <= 2'd0;
            phase     <= '0;
            cnt       <= 8'd0;
            cand_row  <= 2'd0;
            cand_col  <= 2'd0;
            key_col   <= 3'b110;
            keypad    <= 10'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_n;
            col_idx   <= col_idx_n;
            phase     <= phase_n;
            cnt       <= cnt_n;
            cand_row  <= cand_row_n;
            cand_col  <= cand_col_n;
            key_col   <= col_drive(col_idx_n);
            keypad    <= keypad_n;
            key_code  <= key_code_n;
            key_valid <= key_valid_n;
        end
    end

    // col_idx only moves in SCAN or on the way back to it, so the column
    // drive stays frozen on the candidate through DEBOUNCE/HELD/RELEASE.
    always_comb begin
        state_n     = state;
        col_idx_n   = col_idx;
        phase_n     = phase;
        cnt_n       = cnt;
        cand_row_n  = cand_row;
        cand_col_n  = cand_col;
        keypad_n    = keypad;
        key_code_n  = key_code;
        key_valid_n = 1'b0;

        case (state)
            ST_SCAN: begin
                if (phase == PHASE_LAST) begin
                    phase_n = '0;
                    if (single_low(row_s)) begin
                        cand_row_n = low_index(row_s);
                        cand_col_n = col_idx;
                        cnt_n      = 8'd1;
                        state_n    = ST_DEBOUNCE;
                    end else begin
                        col_idx_n = next_col(col_idx);
                    end
                end else begin
                    phase_n = phase + PHASE_ONE;
                end
            end

            ST_DEBOUNCE: begin
                if (row_s == cand_pattern) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == DEB_LAST) begin
                        state_n     = ST_HELD;
                        key_code_n  = cand_code;
                        key_valid_n = 1'b1;
                        keypad_n    = digit_onehot(cand_code);
                    end
                end else begin
                    state_n   = ST_SCAN;
                    col_idx_n = next_col(cand_col);
                    phase_n   = '0;
                end
            end

            ST_HELD: begin
                if (row_s == ROWS_IDLE) begin
                    state_n = ST_RELEASE;
                    cnt_n   = 8'd1;
                end
            end

            ST_RELEASE: begin
                if (row_s == ROWS_IDLE) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == DEB_LAST) begin
                        keypad_n  = 10'd0;
                        state_n   = ST_SCAN;
                        col_idx_n = next_col(cand_col);
                        phase_n   = '0;
                    end
                end else begin
                    state_n = ST_HELD;
                end
            end

            default: begin
                state_n = ST_SCAN;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Brief    : Directed self-checking bench with a behavioural keypad matrix.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_row;
    logic [2:0] key_col;
    logic [9:0] keypad;
    logic [3:0] key_code;
    logic       key_valid;

    logic [3:0][2:0] press_mask;   // [row][col], 1 = key pressed

    int         checks = 0;
    int         errors = 0;
    int         valid_count = 0;
    int         consec = 0;
    logic       prev_valid = 1'b0;
    logic [9:0] keypad_or = 10'd0;

    keypad_scanner #(
        .DEBOUNCE_CYC (20),
        .COL_DWELL    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_row   (key_row),
        .key_col   (key_col),
        .keypad    (keypad),
        .key_code  (key_code),
        .key_valid (key_valid)
    );

    always #5 clk = ~clk;

    // A row reads low when a pressed key sits in a column currently driven low.
    always_comb begin
        key_row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            key_row[r] = ~(|(press_mask[r] & ~key_col));
        end
    end

    always @(posedge clk) begin
        #1;
        if (key_valid) valid_count++;
        if (key_valid && prev_valid) consec++;
        prev_valid = key_valid;
        keypad_or  = keypad_or | keypad;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_keypad(input logic want_zero, input int max, output int n);
        n = 0;
        while (n < max && ((keypad == 10'd0) != want_zero)) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (n < max && !key_valid) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        press_mask = '0;
        wait_cycles(3);
        checks++;
        if (keypad !== 10'd0 || key_valid !== 1'b0 || key_code !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs keypad=%b valid=%b code=%0d required 0/0/0", keypad, key_valid, key_code);
        end
        checks++;
        if (key_col !== 3'b110) begin
            errors++;
            $display("FAIL reset_col got=%b required=110", key_col);
        end
        rst = 1'b0;
        wait_cycles(3);
        checks++;
        if (key_col !== 3'b110) begin
            errors++;
            $display("FAIL scan_col0 got=%b required=110", key_col);
        end
        wait_cycles(1);
        checks++;
        if (key_col !== 3'b101) begin
            errors++;
            $display("FAIL scan_col1 got=%b required=101", key_col);
        end
        wait_cycles(4);
        checks++;
        if (key_col !== 3'b011) begin
            errors++;
            $display("FAIL scan_col2 got=%b required=011", key_col);
        end
        wait_cycles(4);
        checks++;
        if (key_col !== 3'b110) begin
            errors++;
            $display("FAIL scan_wrap got=%b required=110", key_col);
        end
    endtask

    task automatic test_digit_press_release();
        int n;
        int v0;
        v0 = valid_count;
        press_mask[1][1] = 1'b1;
        wait_keypad(1'b0, 40, n);
        checks++;
        if (n > 33) begin
            errors++;
            $display("FAIL digit_latency cycles=%0d required<=33", n);
        end
        checks++;
        if (keypad !== 10'b0000100000) begin
            errors++;
            $display("FAIL digit_keypad got=%b required=0000100000", keypad);
        end
        checks++;
        if (key_valid !== 1'b1) begin
            errors++;
            $display("FAIL digit_valid_with_keypad got=%b required=1", key_valid);
        end
        checks++;
        if (key_code !== 4'd5) begin
            errors++;
            $display("FAIL digit_code got=%0d required=5", key_code);
        end
        wait_cycles(100 - n);
        checks++;
        if (valid_count - v0 !== 1) begin
            errors++;
            $display("FAIL digit_single_pulse got=%0d required=1", valid_count - v0);
        end
        press_mask[1][1] = 1'b0;
        wait_keypad(1'b1, 40, n);
        checks++;
        if (n < 21 || n > 22 || keypad !== 10'd0) begin
            errors++;
            $display("FAIL digit_release cycles=%0d keypad=%b required 21..22 and 0", n, keypad);
        end
        wait_cycles(5);
    endtask

    task automatic test_bounce();
        int n;
        int v0;
        v0 = valid_count;
        keypad_or = 10'd0;
        for (int i = 0; i < 12; i++) begin
            press_mask[0][0] = (i % 2 == 0);
            wait_cycles(5);
        end
        press_mask[0][0] = 1'b0;
        wait_cycles(10);
        checks++;
        if (valid_count - v0 !== 0 || keypad_or !== 10'd0) begin
            errors++;
            $display("FAIL bounce_reject pulses=%0d keypad_or=%b required 0 and 0", valid_count - v0, keypad_or);
        end
        v0 = valid_count;
        press_mask[0][0] = 1'b1;
        wait_cycles(40);
        checks++;
        if (valid_count - v0 !== 1 || key_code !== 4'd1) begin
            errors++;
            $display("FAIL bounce_stable pulses=%0d code=%0d required 1 and 1", valid_count - v0, key_code);
        end
        press_mask[0][0] = 1'b0;
        wait_keypad(1'b1, 40, n);
        wait_cycles(5);
    endtask

    task automatic test_nondigit();
        int n;
        keypad_or = 10'd0;
        press_mask[3][0] = 1'b1;
        wait_valid(40, n);
        checks++;
        if (n > 33 || key_code !== 4'd10) begin
            errors++;
            $display("FAIL star_accept cycles=%0d code=%0d required<=33 and 10", n, key_code);
        end
        wait_cycles(40 - n);
        press_mask[3][0] = 1'b0;
        wait_cycles(30);
        press_mask[3][2] = 1'b1;
        wait_valid(40, n);
        checks++;
        if (n > 33 || key_code !== 4'd11) begin
            errors++;
            $display("FAIL hash_accept cycles=%0d code=%0d required<=33 and 11", n, key_code);
        end
        wait_cycles(40 - n);
        press_mask[3][2] = 1'b0;
        wait_cycles(30);
        checks++;
        if (keypad_or !== 10'd0) begin
            errors++;
            $display("FAIL nondigit_keypad keypad_or=%b required=0", keypad_or);
        end
    endtask

    task automatic test_multikey_lockout();
        int n;
        int v0;
        v0 = valid_count;
        keypad_or = 10'd0;
        press_mask[0][1] = 1'b1;
        press_mask[1][1] = 1'b1;
        wait_cycles(60);
        checks++;
        if (valid_count - v0 !== 0 || keypad_or !== 10'd0) begin
            errors++;
            $display("FAIL ghost_reject pulses=%0d keypad_or=%b required 0 and 0", valid_count - v0, keypad_or);
        end
        press_mask = '0;
        wait_cycles(5);
        press_mask[2][0] = 1'b1;
        wait_valid(40, n);
        checks++;
        if (n > 33 || key_code !== 4'd7 || keypad !== 10'b0010000000) begin
            errors++;
            $display("FAIL lock_first cycles=%0d code=%0d keypad=%b required<=33, 7, 0010000000", n, key_code, keypad);
        end
        wait_cycles(1);
        v0 = valid_count;
        press_mask[2][2] = 1'b1;
        wait_cycles(60);
        checks++;
        if (valid_count - v0 !== 0 || keypad !== 10'b0010000000 || key_code !== 4'd7) begin
            errors++;
            $display("FAIL lock_hold pulses=%0d keypad=%b code=%0d required 0, 0010000000, 7", valid_count - v0, keypad, key_code);
        end
        press_mask[2][0] = 1'b0;
        wait_valid(80, n);
        checks++;
        if (n >= 80 || key_code !== 4'd9 || keypad !== 10'b1000000000) begin
            errors++;
            $display("FAIL lock_second cycles=%0d code=%0d keypad=%b required <80, 9, 1000000000", n, key_code, keypad);
        end
        press_mask[2][2] = 1'b0;
        wait_keypad(1'b1, 40, n);
        wait_cycles(5);
    endtask

    task automatic test_reset_mid_press();
        int n;
        int v0;
        press_mask[2][1] = 1'b1;
        wait_valid(40, n);
        checks++;
        if (n > 33 || keypad !== 10'b0100000000) begin
            errors++;
            $display("FAIL midrst_first cycles=%0d keypad=%b required<=33, 0100000000", n, keypad);
        end
        wait_cycles(5);
        rst = 1'b1;
        wait_cycles(1);
        checks++;
        if (keypad !== 10'd0 || key_valid !== 1'b0 || key_col !== 3'b110) begin
            errors++;
            $display("FAIL midrst_clear keypad=%b valid=%b col=%b required 0, 0, 110", keypad, key_valid, key_col);
        end
        wait_cycles(2);
        v0 = valid_count;
        rst = 1'b0;
        wait_valid(40, n);
        checks++;
        if (n > 33 || keypad !== 10'b0100000000 || key_code !== 4'd8) begin
            errors++;
            $display("FAIL midrst_redetect cycles=%0d keypad=%b code=%0d required<=33, 0100000000, 8", n, keypad, key_code);
        end
        wait_cycles(2);
        checks++;
        if (valid_count - v0 !== 1) begin
            errors++;
            $display("FAIL midrst_pulse got=%0d required=1", valid_count - v0);
        end
        press_mask[2][1] = 1'b0;
        wait_keypad(1'b1, 40, n);
        wait_cycles(5);
    endtask

    task automatic test_valid_spacing();
        checks++;
        if (consec !== 0) begin
            errors++;
            $display("FAIL valid_back_to_back got=%0d required=0", consec);
        end
    endtask

    initial begin
        rst = 1'b1;
        press_mask = '0;
        test_reset();
        test_digit_press_release();
        test_bounce();
        test_nondigit();
        test_multikey_lockout();
        test_reset_mid_press();
        test_valid_spacing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
